// File: rtl/hazard_pkg.sv
// Shared encodings for the MIPS hazard controller: opcodes, functs, Tuse/Tnew,
// forwarding selects and the per-stage tracking record.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDOI = 6'b110111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] TUSE_0 = 2'd0;
    localparam logic [1:0] TUSE_1 = 2'd1;
    localparam logic [1:0] TUSE_2 = 2'd2;
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    typedef struct packed {
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tnew;
        logic       is_md;
        logic       is_div;
    } stage_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// Classifies a D-stage instruction into dest / sources / Tuse / Tnew.
// Purely combinational, zero latency; no flow control.
module instr_class_decoder
    import hazard_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  dest,
    output logic [4:0]  src_rs,
    output logic [4:0]  src_rt,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt,
    output logic [1:0]  tnew,
    output logic        is_md,
    output logic        is_div,
    output logic        is_mdu_op
);

    logic [5:0] op, fn;
    logic [4:0] rs_f, rt_f, rd_f;
    logic calc_r, calc_i, load, store, branch, jal, jr, jalr, lui, md, mf, mt;
    logic use_rs, use_rt;
    logic unused_fields;

    assign op   = instr[31:26];
    assign fn   = instr[5:0];
    assign rs_f = instr[25:21];
    assign rt_f = instr[20:16];
    assign rd_f = instr[15:11];
    assign unused_fields = ^instr[10:6];

    always_comb begin
        calc_r = 1'b0; calc_i = 1'b0; load = 1'b0; store = 1'b0;
        branch = 1'b0; jal = 1'b0; jr = 1'b0; jalr = 1'b0;
        lui = 1'b0; md = 1'b0; mf = 1'b0; mt = 1'b0;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_ADD, FN_SUB, FN_XOR, FN_SLL, FN_SLT: calc_r = 1'b1;
                FN_JR:                                  jr     = 1'b1;
                FN_JALR:                                jalr   = 1'b1;
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:     md     = 1'b1;
                FN_MFHI, FN_MFLO:                       mf     = 1'b1;
                FN_MTHI, FN_MTLO:                       mt     = 1'b1;
                default: ;
            endcase
        end else begin
            case (op)
                OP_ORI, OP_ADDI, OP_ADDOI:  calc_i = 1'b1;
                OP_LW, OP_LB:               load   = 1'b1;
                OP_SW, OP_SB:               store  = 1'b1;
                OP_BEQ, OP_BNE, OP_BGTZ:    branch = 1'b1;
                OP_JAL:                     jal    = 1'b1;
                OP_LUI:                     lui    = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        dest = 5'd0;
        if (calc_r || jalr || mf)
            dest = rd_f;
        else if (calc_i || load || lui)
            dest = rt_f;
        else if (jal)
            dest = 5'd31;
    end

    // Unused sources are reported as $0, which can never stall or forward.
    assign use_rs  = calc_r | calc_i | load | store | branch | jr | jalr | md | mt;
    assign use_rt  = calc_r | store | md | (branch & (op != OP_BGTZ));
    assign src_rs  = use_rs ? rs_f : 5'd0;
    assign src_rt  = use_rt ? rt_f : 5'd0;
    assign tuse_rs = (branch || jr || jalr) ? TUSE_0 : TUSE_1;
    assign tuse_rt = store ? TUSE_2 : (branch ? TUSE_0 : TUSE_1);

    always_comb begin
        tnew = TNEW_0;
        if (load)
            tnew = TNEW_2;
        else if (calc_r || calc_i || lui || mf)
            tnew = TNEW_1;
    end

    assign is_md     = md;
    assign is_div    = md & ((fn == FN_DIV) || (fn == FN_DIVU));
    assign is_mdu_op = md | mf | mt;

endmodule

// File: rtl/hazard_unit.sv
// 5-stage MIPS hazard controller: stall/bubble, D/E/M forwarding, MDU busy interlock.
// Stall and forwarding are combinational; stage tracking updates on the next clk edge.
// Optional perf counters under HAZARD_PERF_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_mdu_stall_cnt,
`endif
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic        bubble_e,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m,
    output logic        mdu_start_e,
    output logic        mdu_busy,
    output logic [4:0]  regaddr_e,
    output logic [4:0]  regaddr_m,
    output logic [4:0]  regaddr_w
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    logic [4:0] dec_dest, dec_rs, dec_rt;
    logic [1:0] dec_tuse_rs, dec_tuse_rt, dec_tnew;
    logic       dec_md, dec_div, dec_mdu_op;

    instr_class_decoder u_dec (
        .instr     (instr_d),
        .dest      (dec_dest),
        .src_rs    (dec_rs),
        .src_rt    (dec_rt),
        .tuse_rs   (dec_tuse_rs),
        .tuse_rt   (dec_tuse_rt),
        .tnew      (dec_tnew),
        .is_md     (dec_md),
        .is_div    (dec_div),
        .is_mdu_op (dec_mdu_op)
    );

    stage_t e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic rs_hz, rt_hz, mdu_hz;
    logic unused_w;

    function automatic logic src_hazard(input logic [4:0] s, input logic [1:0] tuse,
                                        input stage_t e, input stage_t m);
        return (s != 5'd0) &&
               (((e.dest == s) && (e.tnew > tuse)) || ((m.dest == s) && (m.tnew > tuse)));
    endfunction

    function automatic logic [1:0] fwd_sel_d(input logic [4:0] s, input stage_t e, input stage_t m);
        if (s != 5'd0 && e.dest == s && e.tnew == TNEW_0)
            return FWD_E;
        else if (s != 5'd0 && m.dest == s && m.tnew == TNEW_0)
            return FWD_M;
        return FWD_RF;
    endfunction

    // W always has its result ready, so its Tnew is never consulted.
    function automatic logic [1:0] fwd_sel_e(input logic [4:0] s, input stage_t m, input stage_t w);
        if (s != 5'd0 && m.dest == s && m.tnew == TNEW_0)
            return FWD_M;
        else if (s != 5'd0 && w.dest == s)
            return FWD_W;
        return FWD_RF;
    endfunction

    assign rs_hz  = src_hazard(dec_rs, dec_tuse_rs, e_q, m_q);
    assign rt_hz  = src_hazard(dec_rt, dec_tuse_rt, e_q, m_q);
    assign mdu_hz = dec_mdu_op && (mdu_start_e || mdu_busy);

    assign stall       = rs_hz | rt_hz | mdu_hz;
    assign bubble_e    = stall;
    assign fwd_rs_d    = fwd_sel_d(dec_rs, e_q, m_q);
    assign fwd_rt_d    = fwd_sel_d(dec_rt, e_q, m_q);
    assign fwd_rs_e    = fwd_sel_e(e_q.rs, m_q, w_q);
    assign fwd_rt_e    = fwd_sel_e(e_q.rt, m_q, w_q);
    assign fwd_rt_m    = (m_q.rt != 5'd0) && (w_q.dest == m_q.rt);
    assign mdu_start_e = e_q.is_md;
    assign mdu_busy    = (cnt_q != '0);
    assign regaddr_e   = e_q.dest;
    assign regaddr_m   = m_q.dest;
    assign regaddr_w   = w_q.dest;
    assign unused_w    = ^{w_q.rs, w_q.rt, w_q.tnew, w_q.is_md, w_q.is_div};

    always_comb begin
        e_d = '0;
        if (!stall)
            e_d = '{dest: dec_dest, rs: dec_rs, rt: dec_rt, tnew: dec_tnew,
                    is_md: dec_md, is_div: dec_div};
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);
    end

    // The load happens regardless of stall: the op in E has already issued.
    always_comb begin
        cnt_d = cnt_q;
        if (e_q.is_md)
            cnt_d = e_q.is_div ? DIV_LOAD : MUL_LOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_mdu_q, perf_mdu_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall};
        perf_mdu_d   = perf_mdu_q + {31'd0, mdu_hz & ~rs_hz & ~rt_hz};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_mdu_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_mdu_q   <= perf_mdu_d;
        end
    end

    assign perf_stall_cnt     = perf_stall_q;
    assign perf_mdu_stall_cnt = perf_mdu_q;
`endif

endmodule
